// File: rtl/dmem_mmio_pkg.sv
// Shared constants for the data-side memory subsystem: address map,
// seven-segment lookup table and the decimal-point level.
package dmem_mmio_pkg;

    // Memory-mapped register addresses (word aligned, full 32-bit compare)
    localparam logic [31:0] RAM_BASE  = 32'h0000_0000;
    localparam logic [31:0] RAM_LIMIT = 32'h0000_03FF;
    localparam logic [31:0] LED_ADDR  = 32'h0000_7F00;
    localparam logic [31:0] SW_ADDR   = 32'h0000_7F04;
    localparam logic [31:0] DISP_ADDR = 32'h0000_7F08;
    localparam logic [31:0] CNT_ADDR  = 32'h0000_7F0C;

    // Decimal point is active-low and never lit
    localparam logic DP_OFF = 1'b1;

    // Active-low g..a patterns for hex digits 0..F
    localparam logic [6:0] SEG_LUT [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    // Which target an access selects; exactly one per cycle
    typedef enum logic [2:0] {
        SEL_NONE = 3'd0,
        SEL_RAM  = 3'd1,
        SEL_LED  = 3'd2,
        SEL_SW   = 3'd3,
        SEL_DISP = 3'd4,
        SEL_CNT  = 3'd5
    } sel_e;

    // Classify a word-aligned address; RAM spans the low 2^(aw+2) bytes
    function automatic sel_e decode_addr(input logic [31:0] word_addr, input int aw);
        sel_e sel;
        sel = SEL_NONE;
        if ((word_addr >> (aw + 2)) == 32'd0) begin
            sel = SEL_RAM;
        end else if (word_addr == LED_ADDR) begin
            sel = SEL_LED;
        end else if (word_addr == SW_ADDR) begin
            sel = SEL_SW;
        end else if (word_addr == DISP_ADDR) begin
            sel = SEL_DISP;
        end else if (word_addr == CNT_ADDR) begin
            sel = SEL_CNT;
        end
        return sel;
    endfunction

endpackage

// File: rtl/dmem_mmio_seg7_dec.sv
// Combinational hex nibble to active-low seven-segment (g..a) decoder.
module seg7_dec
    import dmem_mmio_pkg::*;
(
    input  logic [3:0] i_nib,
    output logic [6:0] o_seg
);

    // Table lookup, no state
    always_comb begin
        o_seg = SEG_LUT[i_nib];
    end

endmodule

// File: rtl/dmem_mmio.sv
// Data memory + MMIO block behind the single-cycle CPU data port.
// Reads are combinational from addr; writes commit on the rising edge.
// Also scans the DISP register out to an 8-digit multiplexed display.
module dmem_mmio
    import dmem_mmio_pkg::*;
#(
    parameter int SCAN_DIV = 17,   // scan counter width; keep >= 5 so each digit dwells >= 4 clk
    parameter int RAM_AW   = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MemWrite,
    input  logic [31:0] addr,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    input  logic [15:0] sw,
    output logic [15:0] led,
    output logic [7:0]  disp_an,
    output logic [7:0]  disp_seg
);

    // ---------------- address decode ----------------
    logic [31:0]       w_addr_word;
    logic [RAM_AW-1:0] w_ram_idx;
    sel_e              w_sel;
    logic              w_wr_ok;
    logic [1:0]        w_unused_addr_lo;

    assign w_addr_word      = {addr[31:2], 2'b00};
    assign w_ram_idx        = addr[RAM_AW+1:2];
    assign w_unused_addr_lo = addr[1:0];
    // Reset outranks any store presented in the same cycle
    assign w_wr_ok          = MemWrite && !rst;

    // Pick the single target of this access
    always_comb begin
        w_sel = decode_addr(w_addr_word, RAM_AW);
    end

    // ---------------- storage ----------------
    logic [31:0] r_ram [2**RAM_AW];
    logic [15:0] r_led;
    logic [31:0] r_disp;
    logic [31:0] r_cnt;
    logic [15:0] r_sw_meta;
    logic [15:0] r_sw_sync;

    // Data RAM: no reset, contents survive rst
    always_ff @(posedge clk) begin
        if (w_wr_ok && (w_sel == SEL_RAM)) begin
            r_ram[w_ram_idx] <= writedata;
        end
    end

    // LED and DISP registers: CPU writable, cleared by reset
    always_ff @(posedge clk) begin
        if (rst) begin
            r_led  <= 16'h0000;
            r_disp <= 32'h0000_0000;
        end else begin
            if (w_wr_ok && (w_sel == SEL_LED)) begin
                r_led <= writedata[15:0];
            end
            if (w_wr_ok && (w_sel == SEL_DISP)) begin
                r_disp <= writedata;
            end
        end
    end

    // Free-running cycle counter; a CPU store overrides this cycle's increment
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= 32'h0000_0000;
        end else if (w_wr_ok && (w_sel == SEL_CNT)) begin
            r_cnt <= writedata;
        end else begin
            r_cnt <= r_cnt + 32'd1;
        end
    end

    // Two-flop synchroniser for the asynchronous board switches
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sw_meta <= 16'h0000;
            r_sw_sync <= 16'h0000;
        end else begin
            r_sw_meta <= sw;
            r_sw_sync <= r_sw_meta;
        end
    end

    // ---------------- read mux ----------------
    // Zero-latency read of pre-edge state; unmapped addresses read zero
    always_comb begin
        readdata = 32'h0000_0000;
        case (w_sel)
            SEL_RAM:  readdata = r_ram[w_ram_idx];
            SEL_LED:  readdata = {16'h0000, r_led};
            SEL_SW:   readdata = {16'h0000, r_sw_sync};
            SEL_DISP: readdata = r_disp;
            SEL_CNT:  readdata = r_cnt;
            default:  readdata = 32'h0000_0000;
        endcase
    end

    assign led = r_led;

    // ---------------- display scanner ----------------
    logic [SCAN_DIV-1:0] r_scan_cnt;
    logic [2:0]          w_digit;
    logic [3:0]          w_nib;
    logic [6:0]          w_seg;
    logic [7:0]          r_an;
    logic [7:0]          r_seg;

    // Top three counter bits pick the digit, so each digit dwells 2^(SCAN_DIV-3) clk
    assign w_digit = r_scan_cnt[SCAN_DIV-1 -: 3];
    assign w_nib   = r_disp[{w_digit, 2'b00} +: 4];

    seg7_dec u_seg7_dec (
        .i_nib (w_nib),
        .o_seg (w_seg)
    );

    // Advance the scan and register the digit enable / segment pattern
    always_ff @(posedge clk) begin
        if (rst) begin
            r_scan_cnt <= '0;
            r_an       <= 8'hFE;
            r_seg      <= {DP_OFF, SEG_LUT[0]};
        end else begin
            r_scan_cnt <= r_scan_cnt + {{(SCAN_DIV-1){1'b0}}, 1'b1};
            r_an       <= ~(8'h01 << w_digit);
            r_seg      <= {DP_OFF, w_seg};
        end
    end

    assign disp_an  = r_an;
    assign disp_seg = r_seg;

endmodule
